// File: rtl/itch_pkg.sv
// Purpose: shared ITCH encode/decode definitions (type codes, ASCII tags, lengths, side codes).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: msg_type_e matches the parser's LATCHED_TYPE codes so both ends agree on numbering.
package itch_pkg;

  // Decoded message type codes, shared with the receive-side parser.
  typedef enum logic [3:0] {
    MSG_ADD     = 4'd1,
    MSG_DELETE  = 4'd2,
    MSG_CANCEL  = 4'd3,
    MSG_EXECUTE = 4'd4
  } msg_type_e;

  // On-the-wire type bytes.
  localparam logic [7:0] ASCII_ADD     = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_DELETE  = 8'h44;  // 'D'
  localparam logic [7:0] ASCII_CANCEL  = 8'h58;  // 'X'
  localparam logic [7:0] ASCII_EXECUTE = 8'h45;  // 'E'

  // Total message lengths in bytes, type byte included.
  localparam logic [4:0] LEN_ADD     = 5'd26;
  localparam logic [4:0] LEN_DELETE  = 5'd9;
  localparam logic [4:0] LEN_CANCEL  = 5'd13;
  localparam logic [4:0] LEN_EXECUTE = 5'd21;

  // Buy/sell indicator bytes.
  localparam logic [7:0] SIDE_BUY  = 8'h42;  // 'B'
  localparam logic [7:0] SIDE_SELL = 8'h53;  // 'S'

  // Width of the left-justified message image (longest message, ADD).
  localparam int IMG_W = 208;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } enc_state_e;

  function automatic logic [7:0] side_code(input logic side);
    return side ? SIDE_SELL : SIDE_BUY;
  endfunction

endpackage

// File: rtl/itch_msg_pack.sv
// Purpose: maps one decoded order event onto a left-justified ITCH byte image plus its length.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the image is sampled.
// Ports: cmd_* event fields in; img (byte 0 in img[207:200]), len (bytes), ok (type recognised) out.
module itch_msg_pack
  import itch_pkg::*;
(
  input  logic [3:0]       cmd_type,
  input  logic [63:0]      cmd_order_ref,
  input  logic             cmd_side,
  input  logic [31:0]      cmd_shares,
  input  logic [63:0]      cmd_stock,
  input  logic [31:0]      cmd_price,
  input  logic [63:0]      cmd_match,
  output logic [IMG_W-1:0] img,
  output logic [4:0]       len,
  output logic             ok
);

  always_comb begin
    img = '0;
    len = '0;
    ok  = 1'b0;
    case (cmd_type)
      MSG_ADD: begin
        img = {ASCII_ADD, cmd_order_ref, side_code(cmd_side), cmd_shares,
               cmd_stock, cmd_price};
        len = LEN_ADD;
        ok  = 1'b1;
      end
      MSG_DELETE: begin
        img = {ASCII_DELETE, cmd_order_ref, 136'd0};
        len = LEN_DELETE;
        ok  = 1'b1;
      end
      MSG_CANCEL: begin
        img = {ASCII_CANCEL, cmd_order_ref, cmd_shares, 104'd0};
        len = LEN_CANCEL;
        ok  = 1'b1;
      end
      MSG_EXECUTE: begin
        img = {ASCII_EXECUTE, cmd_order_ref, cmd_shares, cmd_match, 40'd0};
        len = LEN_EXECUTE;
        ok  = 1'b1;
      end
      default: begin
        img = '0;
        len = '0;
        ok  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/itch_msg_encoder.sv
// Purpose: serialises decoded order events as an ITCH byte stream, one byte per AXI-Stream beat.
// Latency: first beat valid the cycle after the cmd handshake; back-to-back messages are gapless.
// Backpressure: tdata/tlast/tstrb held while tvalid && !tready; cmd_ready low mid-message.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready + cmd_* fields; m00_axis_* master;
//        msg_count (wrapping), err_count (saturating), busy.
module itch_msg_encoder
  import itch_pkg::*;
#(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_MSG_BYTES          = 26
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [3:0]                          cmd_type,
  input  logic [63:0]                         cmd_order_ref,
  input  logic                                cmd_side,
  input  logic [31:0]                         cmd_shares,
  input  logic [63:0]                         cmd_stock,
  input  logic [31:0]                         cmd_price,
  input  logic [63:0]                         cmd_match,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready,
  output logic [31:0]                         msg_count,
  output logic [15:0]                         err_count,
  output logic                                busy
);

  // Shift register is MAX_MSG_BYTES deep; it must hold the ADD image.
  localparam int SR_W = MAX_MSG_BYTES * 8;

  enc_state_e        state_q, state_d;
  logic [SR_W-1:0]   sr_q;
  logic [4:0]        byte_cnt_q;

  logic [IMG_W-1:0]  pk_img;
  logic [4:0]        pk_len;
  logic              pk_ok;
  logic [SR_W-1:0]   img_ext;

  logic              sending;
  logic              beat_done;
  logic              last_done;
  logic              accept;
  logic              load;
  logic              shift;
  logic              msg_inc;
  logic              err_inc;

  itch_msg_pack u_pack (
    .cmd_type      (cmd_type),
    .cmd_order_ref (cmd_order_ref),
    .cmd_side      (cmd_side),
    .cmd_shares    (cmd_shares),
    .cmd_stock     (cmd_stock),
    .cmd_price     (cmd_price),
    .cmd_match     (cmd_match),
    .img           (pk_img),
    .len           (pk_len),
    .ok            (pk_ok)
  );

  // Left-justify the packed image so the type byte lands in the shift register MSB.
  always_comb begin
    img_ext = '0;
    img_ext[SR_W-1 -: IMG_W] = pk_img;
  end

  assign sending   = (state_q == ST_SEND);
  assign beat_done = sending && m00_axis_tready;
  assign last_done = beat_done && (byte_cnt_q == 5'd0);
  // Ready on the last-byte handshake too, so the next message follows with no bubble.
  assign cmd_ready = (state_q == ST_IDLE) || last_done;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    msg_inc = 1'b0;
    err_inc = 1'b0;

    if (beat_done) begin
      shift = 1'b1;
      if (byte_cnt_q == 5'd0) begin
        msg_inc = 1'b1;
        state_d = ST_IDLE;
      end
    end

    // A new event overrides the shift: load wins over the final shift of the old message.
    if (accept) begin
      if (pk_ok) begin
        load    = 1'b1;
        state_d = ST_SEND;
      end else begin
        err_inc = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      byte_cnt_q <= '0;
      msg_count  <= '0;
      err_count  <= '0;
    end else begin
      state_q <= state_d;

      if (load) begin
        sr_q       <= img_ext;
        byte_cnt_q <= pk_len - 5'd1;
      end else if (shift) begin
        sr_q       <= sr_q << 8;
        byte_cnt_q <= byte_cnt_q - 5'd1;
      end

      if (msg_inc) begin
        msg_count <= msg_count + 32'd1;
      end

      if (err_inc && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  // Outputs derive only from registered state, so they hold naturally under a stall.
  always_comb begin
    m00_axis_tdata      = '0;
    m00_axis_tdata[7:0] = sending ? sr_q[SR_W-1 -: 8] : 8'h00;
    m00_axis_tstrb      = '0;
    m00_axis_tstrb[0]   = sending;
  end

  assign m00_axis_tvalid = sending;
  assign m00_axis_tlast  = sending && (byte_cnt_q == 5'd0);
  assign busy            = sending;

endmodule

// File: tb/tb_itch_msg_encoder.sv
module tb_itch_msg_encoder;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_type = '0;
  logic [63:0]   cmd_order_ref = '0;
  logic          cmd_side = 1'b0;
  logic [31:0]   cmd_shares = '0;
  logic [63:0]   cmd_stock = '0;
  logic [31:0]   cmd_price = '0;
  logic [63:0]   cmd_match = '0;
  logic [W-1:0]  m00_axis_tdata;
  logic [W/8-1:0] m00_axis_tstrb;
  logic          m00_axis_tvalid;
  logic          m00_axis_tlast;
  logic          m00_axis_tready = 1'b1;
  logic [31:0]   msg_count;
  logic [15:0]   err_count;
  logic          busy;

  always #5 clk = ~clk;

  itch_msg_encoder #(.C_M00_AXIS_TDATA_WIDTH(W), .MAX_MSG_BYTES(26)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_order_ref(cmd_order_ref), .cmd_side(cmd_side), .cmd_shares(cmd_shares),
    .cmd_stock(cmd_stock), .cmd_price(cmd_price), .cmd_match(cmd_match),
    .m00_axis_tdata(m00_axis_tdata), .m00_axis_tstrb(m00_axis_tstrb),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .msg_count(msg_count), .err_count(err_count), .busy(busy)
  );

  typedef struct {
    logic [3:0]  typ;
    logic [63:0] oref;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
    logic [63:0] match;
  } cmd_t;

  typedef struct {
    cmd_t       c;
    bit         bp;
    int         exp_len;
    logic [7:0] exp_first;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit bp_mode = 1'b0;

  logic [8:0] exp_q[$];   // {last, byte}
  logic [7:0] rx_q[$];
  int exp_msg = 0;
  int exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] typ, input logic [63:0] oref, input logic side,
                              input logic [31:0] shares, input logic [63:0] stock,
                              input logic [31:0] price, input logic [63:0] match);
    cmd_t c;
    c.typ = typ; c.oref = oref; c.side = side; c.shares = shares;
    c.stock = stock; c.price = price; c.match = match;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input logic [3:0] typ);
    return mk(typ, {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom}, $urandom, {$urandom, $urandom});
  endfunction

  // Reference model: big-endian byte list built straight from the message layouts.
  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      logic [63:0] b;
      b = (v >> (8 * i)) & 64'hFF;
      exp_q.push_back({1'b0, b[7:0]});
    end
  endtask

  task automatic model(input cmd_t c);
    case (c.typ)
      4'd1: begin
        push_be(64'h41, 1); push_be(c.oref, 8); push_be(c.side ? 64'h53 : 64'h42, 1);
        push_be(64'(c.shares), 4); push_be(c.stock, 8); push_be(64'(c.price), 4);
      end
      4'd2: begin push_be(64'h44, 1); push_be(c.oref, 8); end
      4'd3: begin push_be(64'h58, 1); push_be(c.oref, 8); push_be(64'(c.shares), 4); end
      4'd4: begin
        push_be(64'h45, 1); push_be(c.oref, 8); push_be(64'(c.shares), 4); push_be(c.match, 8);
      end
      default: begin
        if (exp_err < 65535) exp_err++;
        return;
      end
    endcase
    exp_q[exp_q.size() - 1][8] = 1'b1;
    exp_msg++;
  endtask

  // Output monitor, sampled on the falling edge: a beat counts if tvalid && tready here.
  logic       prev_stall = 1'b0;
  logic [W-1:0] prev_dat;
  logic       prev_last;
  logic [W/8-1:0] prev_strb;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m00_axis_tvalid), 64'd1);
        chk("stall_tdata", 64'(m00_axis_tdata), 64'(prev_dat));
        chk("stall_tlast", 64'(m00_axis_tlast), 64'(prev_last));
        chk("stall_tstrb", 64'(m00_axis_tstrb), 64'(prev_strb));
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m00_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("beat_data", 64'(m00_axis_tdata), 64'(e[7:0]));
          chk("beat_last", 64'(m00_axis_tlast), 64'(e[8]));
          chk("beat_strb", 64'(m00_axis_tstrb), 64'd1);
        end
        if (rx_q.size() == 0) first_cyc = cyc + 1;
        last_cyc = cyc + 1;
        rx_q.push_back(m00_axis_tdata[7:0]);
      end
      prev_stall = m00_axis_tvalid && !m00_axis_tready;
      prev_dat   = m00_axis_tdata;
      prev_last  = m00_axis_tlast;
      prev_strb  = m00_axis_tstrb;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      m00_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Called and returns at posedge+#1.
  task automatic issue(input cmd_t c, output int waited);
    cmd_valid = 1'b1;
    cmd_type = c.typ; cmd_order_ref = c.oref; cmd_side = c.side; cmd_shares = c.shares;
    cmd_stock = c.stock; cmd_price = c.price; cmd_match = c.match;
    model(c);
    waited = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 300) begin
        chk("cmd_ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_type = 4'($urandom); cmd_order_ref = {$urandom, $urandom}; cmd_shares = $urandom;
    cmd_stock = {$urandom, $urandom}; cmd_price = $urandom; cmd_match = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  vec_t vecs[7];
  logic [7:0] rx_del[$], rx_add[$], rx_exe_bp[$], rx_exe[$];
  logic [7:0] lit_del[9];
  logic [7:0] lit_add[26];

  initial begin
    int waited;
    int n;
    cmd_t c;

    lit_del = '{8'h44, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    lit_add = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h53,
                8'h00, 8'h00, 8'h00, 8'h64, 8'h41, 8'h41, 8'h50, 8'h4C, 8'h20, 8'h20,
                8'h20, 8'h20, 8'h00, 8'h16, 8'hE3, 8'h60};

    vecs[0] = '{c: mk(4'd2, 64'h0102030405060708, 1'b0, 0, 0, 0, 0), bp: 1'b0, exp_len: 9, exp_first: 8'h44};
    vecs[1] = '{c: mk(4'd1, 64'd1, 1'b1, 32'd100, 64'h4141504C20202020, 32'h0016E360, 0),
                bp: 1'b0, exp_len: 26, exp_first: 8'h41};
    vecs[2] = '{c: mk(4'd4, 64'hDEADBEEF00000001, 1'b0, 32'd777, 0, 0, 64'h1122334455667788),
                bp: 1'b1, exp_len: 21, exp_first: 8'h45};
    vecs[3] = '{c: mk(4'd3, 64'd9, 1'b0, 32'd5, 0, 0, 0), bp: 1'b0, exp_len: 13, exp_first: 8'h58};
    vecs[4] = '{c: mk(4'd7, 64'h55, 1'b1, 32'd1, 0, 0, 0), bp: 1'b0, exp_len: 0, exp_first: 8'h00};
    vecs[5] = '{c: mk(4'd2, 64'h0102030405060708, 1'b0, 0, 0, 0, 0), bp: 1'b0, exp_len: 9, exp_first: 8'h44};
    vecs[6] = '{c: mk(4'd4, 64'hDEADBEEF00000001, 1'b0, 32'd777, 0, 0, 64'h1122334455667788),
                bp: 1'b0, exp_len: 21, exp_first: 8'h45};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m00_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m00_axis_tdata), 64'd0);
    chk("rst_tstrb", 64'(m00_axis_tstrb), 64'd0);
    chk("rst_msg_count", 64'(msg_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      bp_mode = vecs[i].bp;
      rx_q.delete();
      issue(vecs[i].c, waited);
      drain();
      bp_mode = 1'b0;
      chk("vec_len", 64'(rx_q.size()), 64'(vecs[i].exp_len));
      if (vecs[i].exp_len > 0) begin
        chk("vec_type_byte", 64'(rx_q[0]), 64'(vecs[i].exp_first));
        if (!vecs[i].bp) begin
          chk("vec_latency", 64'(first_cyc), 64'(acc_cyc + 1));
          chk("vec_no_bubble", 64'(last_cyc - first_cyc + 1), 64'(vecs[i].exp_len));
        end
      end else begin
        chk("invalid_accept_wait", 64'(waited), 64'd0);
        chk("invalid_busy", 64'(busy), 64'd0);
      end
      chk("vec_err_count", 64'(err_count), 64'(exp_err));
      chk("vec_msg_count", 64'(msg_count), 64'(exp_msg));
      if (i == 0) rx_del = rx_q;
      if (i == 1) rx_add = rx_q;
      if (i == 2) rx_exe_bp = rx_q;
      if (i == 6) rx_exe = rx_q;
    end

    for (int i = 0; i < 9; i++) chk("delete_literal", 64'(rx_del[i]), 64'(lit_del[i]));
    for (int i = 0; i < 26; i++) chk("add_literal", 64'(rx_add[i]), 64'(lit_add[i]));
    chk("exec_bp_len", 64'(rx_exe_bp.size()), 64'(rx_exe.size()));
    for (int i = 0; i < rx_exe.size(); i++) chk("exec_bp_same", 64'(rx_exe_bp[i]), 64'(rx_exe[i]));

    // Back-to-back DELETE then CANCEL: 22 beats in 22 consecutive cycles.
    rx_q.delete();
    issue(mk(4'd2, 64'h0102030405060708, 1'b0, 0, 0, 0, 0), waited);
    issue(mk(4'd3, 64'hA5, 1'b0, 32'd5, 0, 0, 0), waited);
    drain();
    chk("b2b_len", 64'(rx_q.size()), 64'd22);
    chk("b2b_span", 64'(last_cyc - first_cyc + 1), 64'd22);
    chk("b2b_cancel_type", 64'(rx_q[9]), 64'h58);
    chk("b2b_msg_count", 64'(msg_count), 64'(exp_msg));

    // Randomised traffic with random backpressure and occasional back-to-back issue.
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      c = rand_cmd(r < 8 ? 4'(r % 4 + 1) : 4'($urandom_range(5, 15)));
      if ($urandom_range(0, 3) == 0) c.typ = 4'd0;
      bp_mode = 1'($urandom_range(0, 1));
      issue(c, waited);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    bp_mode = 1'b0;
    chk("rand_msg_count", 64'(msg_count), 64'(exp_msg));
    chk("rand_err_count", 64'(err_count), 64'(exp_err));

    // Reset in the middle of an ADD.
    rx_q.delete();
    issue(rand_cmd(4'd1), waited);
    n = 0;
    while (rx_q.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reset_beats_seen", 64'(rx_q.size() >= 4), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_msg = 0;
    exp_err = 0;
    @(posedge clk); #1;
    chk("mid_reset_tvalid", 64'(m00_axis_tvalid), 64'd0);
    chk("mid_reset_tlast", 64'(m00_axis_tlast), 64'd0);
    chk("mid_reset_msg_count", 64'(msg_count), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Recovery after reset.
    rx_q.delete();
    issue(mk(4'd2, 64'h0102030405060708, 1'b0, 0, 0, 0, 0), waited);
    drain();
    chk("post_reset_len", 64'(rx_q.size()), 64'd9);
    for (int i = 0; i < 9; i++) chk("post_reset_byte", 64'(rx_q[i]), 64'(lit_del[i]));
    chk("post_reset_msg_count", 64'(msg_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/itch_msg_encoder.md
Name: itch_msg_encoder

Overview:
- Transmit-side counterpart of the ITCH AXI-Stream parser.
- Takes one decoded order event per handshake (type code plus fields) and serialises it as a simplified ITCH byte stream on an AXI-Stream master: one byte per beat, MSB-first, tlast on the final byte.
- Used as the market-data replay source feeding the parser, and for loopback self-test on the FPGA.

Parameters:
- C_M00_AXIS_TDATA_WIDTH, 32: stream data width. The byte sits in [7:0]; upper bits are driven 0. Must be ≥ 8.
- MAX_MSG_BYTES, 26: length of the longest message (Add Order). Sets the shift-register depth.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  event valid
- cmd_ready  out  1  encoder can accept an event
- cmd_type  in  4  1=ADD, 2=DELETE, 3=CANCEL, 4=EXECUTE; any other value is invalid
- cmd_order_ref  in  64  order reference number
- cmd_side  in  1  0='B' (0x42), 1='S' (0x53); used by ADD only
- cmd_shares  in  32  shares for ADD / cancelled shares for CANCEL / executed shares for EXECUTE
- cmd_stock  in  64  8 ASCII chars, space-padded; ADD only
- cmd_price  in  32  price, 4 implied decimals; ADD only
- cmd_match  in  64  match number; EXECUTE only
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {zeros, byte}
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant 'b0001 while tvalid, 0 otherwise
- m00_axis_tvalid  out  1  beat valid
- m00_axis_tlast  out  1  last byte of the message
- m00_axis_tready  in  1  downstream ready
- msg_count  out  32  messages fully sent; wraps
- err_count  out  16  invalid-type events dropped; saturates at 0xFFFF
- busy  out  1  a message is in flight

Behaviour:
Reset and clock:
- Reset is synchronous, active-high, on the single clock clk.
- Reset values: state=IDLE, cmd_ready=1 from the first cycle after reset, tvalid=0, tlast=0, tdata=0, tstrb=0, msg_count=0, err_count=0, busy=0.

Message formats (all multi-byte fields big-endian, type byte first):
- DELETE 'D' (0x44): type + ref[8] = 9 bytes
- CANCEL 'X' (0x58): type + ref[8] + shares[4] = 13 bytes
- EXECUTE 'E' (0x45): type + ref[8] + shares[4] + match[8] = 21 bytes
- ADD 'A' (0x41): type + ref[8] + side[1] + shares[4] + stock[8] + price[4] = 26 bytes

State machine:
- IDLE: cmd_ready=1.
  - Valid type accepted: load the assembled message left-justified into the shift register, set byte_cnt=len-1, go to SEND.
  - Invalid type accepted: consume it, err_count+1 (saturating), stay in IDLE, emit no beats.
- SEND: tvalid=1, tdata[7:0]=shift register MSB byte, tlast=(byte_cnt==0).
  - On tvalid&&tready: shift left 8 and decrement byte_cnt.
  - On the last-byte handshake: msg_count+1.

Handshake rules:
- Latency: first beat has tvalid=1 in the cycle after the cmd handshake.
- Gapless operation: cmd_ready is also 1 in SEND when tlast&&tready. An event accepted in that cycle loads directly and stays in SEND, so its type byte follows the previous tlast beat with zero bubbles. An invalid event accepted there returns the FSM to IDLE.
- Backpressure: while tvalid&&!tready, tdata, tlast and tstrb are held stable. tvalid never drops before its handshake.
- Command fields are sampled only at the handshake; they may change freely afterwards.
- busy = (state==SEND).

Boundary cases:
- Reset mid-message: tvalid=0 on the next edge. The partial message is abandoned with no tlast and no msg_count increment.
- msg_count wraps 0xFFFFFFFF→0.

Decomposition:
- Shared package itch_pkg:
  - message type enum (ADD=1, DELETE=2, CANCEL=3, EXECUTE=4), identical to the parser's LATCHED_TYPE codes
  - ASCII type constants (0x41, 0x44, 0x58, 0x45)
  - per-type length constants
  - side codes
- Sub-module itch_msg_pack: purely combinational. Maps cmd fields to a 208-bit left-justified image, a 5-bit length and a valid flag. The encoder FSM, shift register and counters stay in itch_msg_encoder.

Test Plan:
- DELETE, ref=0x0102030405060708, tready=1 → exactly 9 beats on 9 consecutive cycles: 44 01 02 03 04 05 06 07 08; tlast on the 9th only; tstrb=0001; msg_count=1.
- ADD, ref=1, side=S, shares=100, stock="AAPL    ", price=0x0016E360 → 26 beats:
  - 41, 00×7, 01, 53, 00 00 00 64, 41 41 50 4C 20 20 20 20, 00 16 E3 60
- EXECUTE with tready toggled by a random 50% pattern → byte sequence identical to the no-backpressure case; tdata/tlast stable during every stall.
- DELETE then CANCEL (shares=5) offered back-to-back → the CANCEL type byte 0x58 appears the cycle after the DELETE tlast beat; 22 beats total; msg_count=2.
- cmd_type=7 → accepted in 1 cycle, no tvalid, err_count=1; a following DELETE still encodes correctly.
- rst asserted after 4 beats of an ADD → tvalid=0 next cycle, msg_count=0. Loopback: the encoder output feeds the parser, which reads back LATCHED_TYPE=2, ORDER_REF_HI=0x01020304, ORDER_REF_LO=0x05060708.
